// File: rtl/seg_display_12.sv
// seg_display_12: two-digit multiplexed 7-segment driver for a 0..11 counter.
// The ones and tens digits are time-multiplexed, each held for REFRESH_DIV
// clock cycles. The input value is sampled once per full two-digit frame so
// that both digits always show the same value. Values 12..15 show dashes.
// Optional build macro: SEG_LEADING_ZERO_EN -- when defined, values 0..9
// show a leading "0" on the tens digit; otherwise the tens digit is blank
// (its anode is still scanned so the brightness of the ones digit is the same).
// Handshake: none; the display free-runs. The input is sampled only on the
// frame-end edge, and the outputs are registered one cycle after the scan state.
module seg_display_12 #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [3:0] count,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;

`ifdef SEG_LEADING_ZERO_EN
    localparam logic [6:0] TENS_LOW = SEG_ZERO;
`else
    localparam logic [6:0] TENS_LOW = SEG_BLANK;
`endif

    // Scan state: which digit is currently being driven
    typedef enum logic {
        SCAN_ONES = 1'b0,
        SCAN_TENS = 1'b1
    } scan_e;

    logic [CNT_W-1:0] refresh_q, refresh_d;
    scan_e            scan_q, scan_d;
    logic [3:0]       shadow_q, shadow_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             slot_end;
    logic             tens_w;
    logic [3:0]       ones_w;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // State register; reset abandons the current frame with no partial latch
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            refresh_q <= '0;
            scan_q    <= SCAN_ONES;
            shadow_q  <= 4'd0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            refresh_q <= refresh_d;
            scan_q    <= scan_d;
            shadow_q  <= shadow_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    // Refresh counter, scan toggle and frame-end latch of the input value
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        scan_d    = scan_q;
        shadow_d  = shadow_q;
        slot_end  = (refresh_q == REFRESH_LAST);
        if (slot_end) begin
            refresh_d = '0;
            case (scan_q)
                SCAN_ONES: scan_d = SCAN_TENS;
                SCAN_TENS: begin
                    scan_d   = SCAN_ONES;
                    shadow_d = count;
                end
                default:   scan_d = SCAN_ONES;
            endcase
        end
    end

    // Split the shadow value into tens (0/1) and ones digits
    always_comb begin
        tens_w = (shadow_q >= 4'd10);
        ones_w = shadow_q - (tens_w ? 4'd10 : 4'd0);
    end

    // Next output pattern from the current scan state and shadow value
    always_comb begin
        an_d  = AN_ONES;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (scan_q == SCAN_TENS) begin
            an_d = AN_TENS;
            if (shadow_q >= 4'd12) begin
                seg_d = SEG_DASH;
            end else if (tens_w) begin
                seg_d = SEG_ONE;
            end else begin
                seg_d = TENS_LOW;
            end
        end else begin
            an_d = AN_ONES;
            if (shadow_q >= 4'd12) begin
                seg_d = SEG_DASH;
            end else begin
                seg_d = digit_seg(ones_w);
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_12.sv
// tb_seg_display_12: directed bench for seg_display_12 with REFRESH_DIV = 4.
// A frame is 8 cycles: edges 1..4 after a frame start drive the ones digit,
// edges 5..8 the tens digit, and edge 8 latches the input for the next frame.
module tb_seg_display_12;

  localparam int DIV = 4;
  localparam int W   = 12;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_DASH  = 7'b0111111;
  localparam logic [6:0] S_0     = 7'b1000000;
  localparam logic [6:0] S_1     = 7'b1111001;
  localparam logic [6:0] S_3     = 7'b0110000;
  localparam logic [6:0] S_5     = 7'b0010010;
  localparam logic [6:0] S_7     = 7'b1111000;
  localparam logic [6:0] S_9     = 7'b0010000;
`ifdef SEG_LEADING_ZERO_EN
  localparam logic [6:0] S_TENS0 = S_0;
`else
  localparam logic [6:0] S_TENS0 = S_BLANK;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] count;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int cyc;
  int rel;
  int n_cmp;
  int n_fail;
  logic final_chk;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  string        name_q[$];

  seg_display_12 #(.REFRESH_DIV(DIV)) dut (
    .clk_100MHz(clk),
    .reset     (rst_n),
    .count     (count),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // driver tasks
  task automatic exp_push(input int k, input logic [3:0] a, input logic [6:0] s, input string nm);
    exp_q.push_back({a, s, 1'b1});
    cyc_q.push_back(rel + k);
    name_q.push_back(nm);
  endtask

  task automatic at_edge(input int k);
    while (cyc < rel + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor / scoreboard: samples on the falling edge
  initial begin
    n_cmp = 0;
    n_fail = 0;
  end

  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] want;
    string nm;
    got = {an, seg, dp};
    n_cmp = n_cmp + 1;
    if (!(an == AN_OFF || an == AN_ONES || an == AN_TENS)) begin
      n_fail = n_fail + 1;
      $display("FAIL an_onehot cyc=%0d an=%b", cyc, an);
    end
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      n_cmp = n_cmp + 1;
      want = exp_q.pop_front();
      nm = name_q.pop_front();
      if (cyc_q[0] < cyc) begin
        n_fail = n_fail + 1;
        $display("FAIL %s missed sample cyc=%0d due=%0d", nm, cyc, cyc_q[0]);
      end else if (got !== want) begin
        n_fail = n_fail + 1;
        $display("FAIL %s cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 nm, cyc, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
      end
      void'(cyc_q.pop_front());
    end
    if (final_chk && cyc_q.size() > 0) begin
      n_cmp = n_cmp + 1;
      n_fail = n_fail + 1;
      $display("FAIL drain_timeout pending=%0d", cyc_q.size());
      exp_q.delete();
      cyc_q.delete();
      name_q.delete();
    end
  end

  // stimulus
  initial begin
    final_chk = 1'b0;
    rst_n = 1'b0;
    count = 4'd7;
    rel = 0;
    exp_push(1, AN_OFF, S_BLANK, "rst_hold1");
    exp_push(2, AN_OFF, S_BLANK, "rst_hold2");
    at_edge(3);
    rst_n = 1'b1;
    rel = cyc;

    // first frame shows 0 from reset, then 7 for two frames
    exp_push(1,  AN_ONES, S_0,     "post_rst_ones");
    exp_push(4,  AN_ONES, S_0,     "f0_ones_end");
    exp_push(5,  AN_TENS, S_TENS0, "f0_tens");
    exp_push(8,  AN_TENS, S_TENS0, "f0_tens_end");
    exp_push(9,  AN_ONES, S_7,     "c7_ones");
    exp_push(12, AN_ONES, S_7,     "c7_ones_end");
    exp_push(13, AN_TENS, S_TENS0, "c7_tens");
    exp_push(16, AN_TENS, S_TENS0, "c7_tens_end");
    exp_push(17, AN_ONES, S_7,     "c7_f2_ones");
    exp_push(21, AN_TENS, S_TENS0, "c7_f2_tens");
    at_edge(16);
    count = 4'd11;
    exp_push(24, AN_TENS, S_TENS0, "c7_hold_tens");
    exp_push(25, AN_ONES, S_1,     "c11_ones");
    exp_push(28, AN_ONES, S_1,     "c11_ones_end");
    exp_push(29, AN_TENS, S_1,     "c11_tens");
    exp_push(32, AN_TENS, S_1,     "c11_tens_end");
    at_edge(32);
    count = 4'd10;
    exp_push(40, AN_TENS, S_1,     "c11_hold_tens");
    exp_push(41, AN_ONES, S_0,     "c10_ones");
    exp_push(44, AN_ONES, S_0,     "c10_ones_end");
    exp_push(45, AN_TENS, S_1,     "c10_tens");
    exp_push(48, AN_TENS, S_1,     "c10_tens_end");
    at_edge(48);
    count = 4'd13;
    exp_push(57, AN_ONES, S_DASH,  "c13_ones");
    exp_push(60, AN_ONES, S_DASH,  "c13_ones_end");
    exp_push(61, AN_TENS, S_DASH,  "c13_tens");
    exp_push(64, AN_TENS, S_DASH,  "c13_tens_end");
    at_edge(64);
    count = 4'd3;
    exp_push(73, AN_ONES, S_3,     "c3_ones");
    at_edge(74);
    count = 4'd5;  // mid ones slot: must not appear before the frame-end latch
    exp_push(76, AN_ONES, S_3,     "c3_hold_ones");
    exp_push(77, AN_TENS, S_TENS0, "c3_hold_tens");
    exp_push(80, AN_TENS, S_TENS0, "c3_hold_tens_end");
    exp_push(81, AN_ONES, S_5,     "c5_ones");
    exp_push(84, AN_ONES, S_5,     "c5_ones_end");
    at_edge(84);
    count = 4'd9;
    exp_push(89, AN_ONES, S_9,     "c9_ones");
    exp_push(93, AN_TENS, S_TENS0, "c9_tens");
    at_edge(94);
    // reset in the middle of the tens slot: outputs clear before this cycle's sample
    exp_push(94, AN_OFF, S_BLANK, "rst_async");
    exp_push(95, AN_OFF, S_BLANK, "rst_mid_hold");
    exp_push(96, AN_OFF, S_BLANK, "rst_mid_hold2");
    rst_n = 1'b0;
    at_edge(96);
    rst_n = 1'b1;
    rel = cyc;
    exp_push(1,  AN_ONES, S_0,     "rel_ones0");
    exp_push(4,  AN_ONES, S_0,     "rel_no_partial");
    exp_push(5,  AN_TENS, S_TENS0, "rel_tens");
    exp_push(8,  AN_TENS, S_TENS0, "rel_tens_end");
    exp_push(9,  AN_ONES, S_9,     "rel_c9_ones");
    exp_push(12, AN_ONES, S_9,     "rel_c9_ones_end");
    exp_push(13, AN_TENS, S_TENS0, "rel_c9_tens");
    at_edge(13);

    for (int i = 0; i < 20 && cyc_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    final_chk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_12.md
SEG_DISPLAY_12 -- requirements
Module: seg_display_12

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100_000, meaning clk_100MHz cycles per digit slot (1 ms at 100 MHz); legal range >= 2.
REQ-002 SHALL have port clk_100MHz  input  1  system clock, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port count  input  4  binary value from the upstream 0..11 counter (leds bus); 12..15 are out of range.
REQ-005 SHALL have port an  output  4  digit anodes, active-low; an[0] is the ones digit, an[1] is the tens digit, an[3:2] are unused.
REQ-006 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-007 SHALL have port dp  output  1  decimal point, active-low, held 1 (off) at all times.

Function
REQ-008 SHALL hold a refresh counter counting 0..REFRESH_DIV-1 and wrapping to 0, advancing every cycle.
REQ-009 SHALL hold a 1-bit scan index (0 = ones, 1 = tens) that toggles on the edge where the refresh counter equals REFRESH_DIV-1.
REQ-010 SHALL latch count into a shadow register on the edge where the refresh counter equals REFRESH_DIV-1 and the scan index is 1 (end of a full two-digit frame), so each frame displays one coherent value.
REQ-011 SHALL ignore changes on count between latch edges; the latency from a count change to its display is at most 2*REFRESH_DIV+1 cycles.
REQ-012 SHALL compute tens = (shadow >= 10) ? 1 : 0 and ones = shadow - 10*tens, using 4-bit arithmetic.
REQ-013 SHALL register an, seg and dp, so each output reflects the scan index and shadow value of the previous cycle (1-cycle pipeline).
REQ-014 SHALL drive an = 4'b1110 when the scan index is 0 and an = 4'b1101 when it is 1; an[3:2] SHALL never be 0.
REQ-015 SHALL use the following digit encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, dash=0111111.
REQ-016 SHALL drive seg = dash on both digits when the shadow value is 12..15.
REQ-017 SHALL drive the tens digit as "1" when the shadow value is 10 or 11.
REQ-018 SHALL drive the tens digit for shadow values 0..9 per REQ-024.
REQ-019 SHALL never drive more than one an bit low in any cycle.

Reset
REQ-020 SHALL, while reset = 0, asynchronously force the refresh counter = 0, scan index = 0, shadow = 0, an = 4'b1111, seg = 7'b1111111, dp = 1.
REQ-021 SHALL, on the first rising edge after reset deasserts, output an = 4'b1110 and seg = 1000000 (ones digit of shadow value 0).
REQ-022 SHALL, when reset asserts mid-frame, abandon the frame immediately with no partial latch; after release, a full frame SHALL elapse before the first new latch.

Configuration
REQ-023 SHALL support the macro SEG_LEADING_ZERO_EN.
REQ-024 SHALL, with SEG_LEADING_ZERO_EN defined, show the tens digit for shadow values 0..9 as "0" (1000000); without it, the tens digit SHALL be blank (1111111) while an[1] is still scanned.

Verification
REQ-025 SHALL cover this scenario (bench uses REFRESH_DIV=4): reset held low -> an=1111, seg=1111111, dp=1; on release -> an toggles 1110/1101 every 4 cycles.
REQ-026 SHALL cover this scenario: count=7 held for 2 frames -> ones slot seg=1111000; tens slot seg=1111111 without the macro, 1000000 with it.
REQ-027 SHALL cover this scenario: count=11 -> both slots seg=1111001; count=10 -> ones slot 1000000, tens slot 1111001.
REQ-028 SHALL cover this scenario: count=13 -> both slots seg=0111111.
REQ-029 SHALL cover this scenario: count changes 3->5 at the middle of the ones slot -> display stays 3 until the next frame-end latch, then shows 5 within 2*REFRESH_DIV+1 cycles.
REQ-030 SHALL cover this scenario: reset pulsed low during the tens slot with count=9 -> outputs go to their reset values in the same cycle; after release, the ones slot shows 0 until the first latch, then shows 9.
